// File: rtl/arbiter_pkg.sv
// Shared constants and types for the 4-channel round-robin arbiter.
package arbiter_pkg;
    localparam int NUM_CH    = 4;
    localparam int DEF_WIDTH = 8;

    typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/arbiter_rr_pick.sv
// Cyclic first-requester search starting at the round-robin pointer.
module rr_pick
    import arbiter_pkg::*;
(
    input  logic [3:0] i_req,
    input  ch_idx_t    i_ptr,
    output ch_idx_t    o_sel,
    output logic       o_valid
);
    ch_idx_t w_idx;

    always_comb begin
        o_sel   = i_ptr;
        o_valid = 1'b0;
        w_idx   = i_ptr;
        // Walk from highest offset down so the nearest requester wins last.
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + ch_idx_t'(k);
            if (i_req[w_idx]) begin
                o_sel   = w_idx;
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbiter.sv
// Round-robin arbiter over four data channels with a 2-stage registered output.
// Optional build macro ARB_SKIP_IDLE_EN: skip channels whose data is zero.
module arbiter
    import arbiter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);
    ch_idx_t          r_ptr;
    logic [WIDTH-1:0] r_s1;
    logic [3:0]       w_req;
    ch_idx_t          w_sel;
    logic             w_valid;
    logic [WIDTH-1:0] w_data;

`ifdef ARB_SKIP_IDLE_EN
    assign w_req = {|d, |c, |b, |a};
`else
    assign w_req = 4'b1111;
`endif

    rr_pick u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_sel   (w_sel),
        .o_valid (w_valid)
    );

    always_comb begin
        w_data = '0;
        if (w_valid) begin
            unique case (w_sel)
                2'd0:    w_data = a;
                2'd1:    w_data = b;
                2'd2:    w_data = c;
                default: w_data = d;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_s1  <= '0;
            out   <= '0;
        end else begin
            r_s1 <= w_data;
            out  <= r_s1;
            // With no requester the pointer holds so the search restarts in place.
            if (w_valid)
                r_ptr <= w_sel + 2'd1;
        end
    end
endmodule

// File: tb/tb_arbiter.sv
// Randomized + directed bench for arbiter (WIDTH=8 and WIDTH=16 instances) against a queue-based model.
module tb_arbiter;
`ifdef ARB_SKIP_IDLE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, c8 = '0, d8 = '0;
    logic [15:0] a16 = '0, b16 = '0, c16 = '0, d16 = '0;
    logic [7:0]  out8;
    logic [15:0] out16;

    int nchk = 0;
    int nfail = 0;

    int          p8 = 0, p16 = 0;
    logic [15:0] q8[$];
    logic [15:0] q16[$];

    always #5 clk = ~clk;

    arbiter #(.WIDTH(8)) u_dut8 (
        .a(a8), .b(b8), .c(c8), .d(d8), .clk(clk), .rst(rst), .out(out8)
    );
    arbiter #(.WIDTH(16)) u_dut16 (
        .a(a16), .b(b16), .c(c16), .d(d16), .clk(clk), .rst(rst), .out(out16)
    );

    // Channel chosen this edge: first eligible channel at or after p, cyclically.
    function automatic logic [15:0] pick(input logic [3:0][15:0] v, input int p, output int np);
        np = p;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (!SKIP || v[i] != 16'd0) begin
                np = (i + 1) % 4;
                return v[i];
            end
        end
        return 16'd0;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        p8 = 0;
        p16 = 0;
        q8.delete();
        q16.delete();
    endtask

    // One rising edge: update the model from the inputs present at the edge, then compare.
    task automatic step(input string tag);
        int np;
        @(posedge clk);
        if (rst) begin
            q8.push_back(pick({16'(d8), 16'(c8), 16'(b8), 16'(a8)}, p8, np));
            p8 = np;
            q16.push_back(pick({d16, c16, b16, a16}, p16, np));
            p16 = np;
            if (q8.size() > 2) void'(q8.pop_front());
            if (q16.size() > 2) void'(q16.pop_front());
        end
        #1;
        check({tag, "_w8"},  16'(out8), (q8.size()  == 2) ? q8[0]  : 16'd0);
        check({tag, "_w16"}, out16,     (q16.size() == 2) ? q16[0] : 16'd0);
    endtask

    task automatic set_both(input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] vc, input logic [15:0] vd);
        a8 = va[7:0]; b8 = vb[7:0]; c8 = vc[7:0]; d8 = vd[7:0];
        a16 = va; b16 = vb; c16 = vc; d16 = vd;
    endtask

    initial begin
        logic [7:0]  exp_seq[6];
        logic [15:0] exp16[4];
        exp_seq = '{8'd0, 8'd10, 8'd26, 8'd14, 8'd9, 8'd10};
        exp16   = '{16'hFFFF, 16'd1, 16'd1, 16'd1};

        // Reset state
        model_reset();
        set_both(16'd10, 16'd26, 16'd14, 16'd9);
        #2;
        check("reset_out8", 16'(out8), 16'd0);
        check("reset_out16", out16, 16'd0);
        repeat (2) step("in_reset");

        // Basic rotation from release
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("rot");
            check("rot_const", 16'(out8), 16'(exp_seq[i]));
        end

        // Asynchronous reset between edges discards in-flight data
        @(negedge clk); #2; rst = 1'b0; #1;
        model_reset();
        check("midrst_out8", 16'(out8), 16'd0);
        check("midrst_out16", out16, 16'd0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("restart");
            check("restart_const", 16'(out8), 16'(exp_seq[i]));
        end

        // Zero channel: consumes a slot by default, skipped with the macro
        set_both(16'd10, 16'd0, 16'd14, 16'd9);
        repeat (8) step("bzero");

        // All channels idle, then only d requests
        set_both(16'd0, 16'd0, 16'd0, 16'd0);
        repeat (3) step("idle");
        set_both(16'd0, 16'd0, 16'd0, 16'd9);
        repeat (4) step("d_only");

        // Wide data passes through unmodified
        @(negedge clk); rst = 1'b0; model_reset();
        set_both(16'hFFFF, 16'd1, 16'd1, 16'd1);
        @(negedge clk); rst = 1'b1;
        step("w16_first");
        for (int i = 0; i < 4; i++) begin
            step("w16");
            check("w16_const", out16, exp16[i]);
        end

        // Randomized traffic with frequent zero channels and occasional resets
        for (int n = 0; n < 200; n++) begin
            logic [15:0] v[4];
            for (int k = 0; k < 4; k++)
                v[k] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
            set_both(v[0], v[1], v[2], v[3]);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0; #1;
                model_reset();
                check("rnd_rst8", 16'(out8), 16'd0);
                @(negedge clk); rst = 1'b1;
            end
            step("rnd");
        end

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every channel and of out.
REQ-002 SHALL have parameter NUM_CH, default 4, fixed number of channels; 4 is the only supported value.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port a  input  WIDTH  channel 0 data.
REQ-006 SHALL have port b  input  WIDTH  channel 1 data.
REQ-007 SHALL have port c  input  WIDTH  channel 2 data.
REQ-008 SHALL have port d  input  WIDTH  channel 3 data.
REQ-009 SHALL have port out  output  WIDTH  registered granted channel data.
REQ-010 SHALL use the positional port order a, b, c, d, clk, rst, out.
REQ-011 SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-012 SHALL hold a 2-bit round-robin pointer ptr, a stage-1 data register s1 and a stage-2 output register out.
REQ-013 SHALL, on each rising clk edge with rst high, load s1 with the data of the channel selected by the pick logic.
REQ-014 SHALL, on the same edge, load out with the previous s1 value, giving a fixed latency of 2 clocks from selection to out.
REQ-015 SHALL, in default mode, select channel ptr and advance ptr to (ptr+1) mod 4 on every edge, with no data dependence.
REQ-016 SHALL implement the ptr wrap as 3 -> 0, in both modes.
REQ-017 SHALL keep all arithmetic unsigned with WIDTH-bit data passed through unmodified (no truncation or extension).
REQ-018 SHALL produce no combinational path from any input to out.
REQ-019 SHALL let input changes affect only the value captured at the next edge.

Reset
REQ-020 SHALL, while rst is low, asynchronously force ptr=0 (channel a), s1=0 and out=0, independent of clk.
REQ-021 SHALL, when reset asserts mid-operation, discard in-flight s1 data.
REQ-022 SHALL restart arbitration from channel a at the first edge after rst deasserts.
REQ-023 SHALL make the first non-reset out value appear at the second rising edge after deassertion.

Configuration
REQ-024 SHALL support the macro ARB_SKIP_IDLE_EN.
REQ-025 SHALL, with ARB_SKIP_IDLE_EN defined, treat a channel as requesting when its data is nonzero.
REQ-026 SHALL, with the macro defined, select the first requesting channel at or after ptr in cyclic order, and set ptr to (selected+1) mod 4.
REQ-027 SHALL, with the macro defined and all channels zero, load s1 with 0 and leave ptr unchanged.
REQ-028 SHALL, without the macro, use the pure rotation of REQ-015, so zero-valued channels still consume a slot.

Structure
REQ-029 SHALL place the constant NUM_CH, the default WIDTH and a 2-bit channel-index typedef in the shared package arbiter_pkg.
REQ-030 SHALL place the cyclic first-requester pick logic in one sub-module, rr_pick, instantiated by arbiter.
REQ-031 rr_pick SHALL take the 4-bit request vector and ptr as inputs.
REQ-032 rr_pick SHALL output the selected index and a valid bit.
REQ-033 SHALL, without ARB_SKIP_IDLE_EN, tie the rr_pick request vector to all-ones.

Verification
REQ-034 SHALL cover: a=10, b=26, c=14, d=9, rst pulse then release -> out=0 at edge 1, then 10, 26, 14, 9, 10, 26... from edge 2 onward.
REQ-035 SHALL cover: rst driven low mid-sequence between edges -> out=0 immediately; after release out restarts with 10 at the second edge.
REQ-036 SHALL cover: default mode with b=0, others as REQ-034 -> out cycle 10, 0, 14, 9.
REQ-037 SHALL cover: ARB_SKIP_IDLE_EN with b=0 -> out cycle 10, 14, 9, 10.
REQ-038 SHALL cover: ARB_SKIP_IDLE_EN with all inputs 0 for 3 edges, then d=9 -> out=0 throughout, then 9 two edges after d is set.
REQ-039 SHALL cover: WIDTH=16 with a=16'hFFFF, others 1 -> out cycle 16'hFFFF, 1, 1, 1 with no truncation.
